// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, STOP_BITS stop) with Send/Ready handshake.
// Optional feature macro: TX_FIFO_EN adds a FIFO_DEPTH-entry input FIFO and the Fifo_Level output.
module uart_tx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        Clock_2br,
    input  logic                        Reset,
    input  logic                        Send,
    input  logic [DATA_BITS-1:0]        Data,
    input  logic [1:0]                  Parity_Mode,
    output logic                        Ready,
    output logic                        Busy,
    output logic                        Done,
`ifdef TX_FIFO_EN
    output logic [$clog2(FIFO_DEPTH):0] Fifo_Level,
`endif
    output logic                        Tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_param: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  par_bit;
    logic                  par_en;

    logic                  ld_avail;
    logic [DATA_BITS-1:0]  ld_data;
    logic [1:0]            ld_mode;
    logic                  baud_tc;
    logic                  last_stop_tc;
    logic                  start_frame;

    assign baud_tc      = (baud_cnt == CNT_TC);
    assign last_stop_tc = (state == STOP) && (bit_idx == LAST_STOP) && baud_tc;
    // A new frame is loaded from IDLE, or straight off the final stop bit when a word is waiting.
    assign start_frame  = ld_avail && ((state == IDLE) || last_stop_tc);

`ifdef TX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]           mode;
        logic [DATA_BITS-1:0] data;
    } fifo_entry_t;

    fifo_entry_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              push;

    assign push     = Send && Ready;
    assign ld_avail = (Fifo_Level != '0);
    assign ld_data  = fifo_mem[rd_ptr].data;
    assign ld_mode  = fifo_mem[rd_ptr].mode;

    always_comb begin
        level_nxt = Fifo_Level;
        if (push && !start_frame) begin
            level_nxt = Fifo_Level + LVL_W'(1);
        end else if (!push && start_frame) begin
            level_nxt = Fifo_Level - LVL_W'(1);
        end
    end

    always_ff @(posedge Clock_2br) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {Parity_Mode, Data};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge Clock_2br) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Fifo_Level <= '0;
            Ready      <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (start_frame) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            Fifo_Level <= level_nxt;
            Ready      <= (level_nxt != LVL_FULL);
        end
    end
`else
    assign ld_avail = Send && Ready;
    assign ld_data  = Data;
    assign ld_mode  = Parity_Mode;
`endif

    // Payload shifter and parity latch; the word is frozen for the whole frame.
    always_ff @(posedge Clock_2br) begin
        if (Reset) begin
            shift_reg <= '0;
            par_bit   <= 1'b0;
            par_en    <= 1'b0;
        end else if (start_frame) begin
            shift_reg <= ld_data;
            par_bit   <= (ld_mode == 2'b10) ? ~^ld_data : ^ld_data;
            par_en    <= (ld_mode == 2'b01) || (ld_mode == 2'b10);
        end else if (baud_tc && ((state == START) || (state == DATA))) begin
            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge Clock_2br) begin
        if (Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            Tx       <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
`ifndef TX_FIFO_EN
            Ready    <= 1'b1;
`endif
        end else begin
            // Registered so it lands on the last cycle of the final stop bit.
            Done <= (state == STOP) && (bit_idx == LAST_STOP) && (baud_cnt == CNT_PRE);

            if ((state == IDLE) || baud_tc) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start_frame) begin
                        state   <= START;
                        Tx      <= 1'b0;
                        Busy    <= 1'b1;
                        bit_idx <= '0;
`ifndef TX_FIFO_EN
                        Ready   <= 1'b0;
`endif
                    end else begin
                        Tx   <= 1'b1;
                        Busy <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        state   <= DATA;
                        Tx      <= shift_reg[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (par_en) begin
                                state <= PARITY;
                                Tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                Tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            Tx      <= shift_reg[0];
                        end
                    end
                end
                PARITY: begin
                    if (baud_tc) begin
                        state   <= STOP;
                        Tx      <= 1'b1;
                        bit_idx <= '0;
                    end
                end
                STOP: begin
                    if (baud_tc) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            if (start_frame) begin
                                state <= START;
                                Tx    <= 1'b0;
                            end else begin
                                state <= IDLE;
                                Busy  <= 1'b0;
`ifndef TX_FIFO_EN
                                Ready <= 1'b1;
`endif
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Tx    <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two configurations (8N1 and 5-bit/2-stop) checked every cycle against a frame-list model.
module tb_uart_tx_param;

    localparam int CPB = 4;
    localparam int NI  = 2;
`ifdef TX_FIFO_EN
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
`else
    localparam int LAT   = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       send  [NI];
    logic [8:0] data  [NI];
    logic [1:0] mode  [NI];
    logic       ready [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic       tx    [NI];
`ifdef TX_FIFO_EN
    logic [2:0] lvl   [NI];
`endif

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .Clock_2br(clk), .Reset(rst), .Send(send[0]), .Data(data[0][7:0]), .Parity_Mode(mode[0]),
        .Ready(ready[0]), .Busy(busy[0]), .Done(done[0]),
`ifdef TX_FIFO_EN
        .Fifo_Level(lvl[0]),
`endif
        .Tx(tx[0]));

    uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .Clock_2br(clk), .Reset(rst), .Send(send[1]), .Data(data[1][4:0]), .Parity_Mode(mode[1]),
        .Ready(ready[1]), .Busy(busy[1]), .Done(done[1]),
`ifdef TX_FIFO_EN
        .Fifo_Level(lvl[1]),
`endif
        .Tx(tx[1]));

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int db(input int i);
        return (i == 0) ? 8 : 5;
    endfunction

    function automatic int sb(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Model: each frame is a list of bit values, each held CPB cycles.
    bit         m_active [NI];
    int         m_pos    [NI];
    int         m_len    [NI];
    bit         m_bits   [NI][16];
    bit         m_ready  [NI];
    bit         m_tx     [NI];
    bit         m_busy   [NI];
    bit         m_done   [NI];
    int         m_qn     [NI];
    logic [10:0] mq      [NI][8];
    bit         check_en = 1'b0;

    function automatic void load_frame(input int i, input logic [10:0] w);
        int n;
        bit p;
        p = 1'b0;
        m_bits[i][0] = 1'b0;
        for (int k = 0; k < db(i); k++) begin
            m_bits[i][1+k] = w[k];
            p = p ^ w[k];
        end
        n = 1 + db(i);
        if (w[10:9] == 2'b01) begin
            m_bits[i][n] = p;
            n++;
        end else if (w[10:9] == 2'b10) begin
            m_bits[i][n] = !p;
            n++;
        end
        for (int s = 0; s < sb(i); s++) begin
            m_bits[i][n] = 1'b1;
            n++;
        end
        m_len[i]    = n * CPB;
        m_pos[i]    = 0;
        m_active[i] = 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                bit acc;
                bit st;
                logic [10:0] w;
                w = {mode[i], data[i]};
                if (rst) begin
                    m_active[i] = 1'b0;
                    m_qn[i]     = 0;
                end else begin
                    acc = send[i] && m_ready[i];
                    st  = 1'b0;
                    if (m_active[i]) begin
                        m_pos[i]++;
                        if (m_pos[i] == m_len[i]) begin
                            m_active[i] = 1'b0;
`ifdef TX_FIFO_EN
                            if (m_qn[i] > 0) st = 1'b1;
`endif
                        end
                    end
`ifdef TX_FIFO_EN
                    else if (m_qn[i] > 0) st = 1'b1;
                    if (st) begin
                        load_frame(i, mq[i][0]);
                        for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
                        m_qn[i]--;
                    end
                    if (acc) begin
                        mq[i][m_qn[i]] = w;
                        m_qn[i]++;
                    end
`else
                    else if (acc) st = 1'b1;
                    if (st) load_frame(i, w);
`endif
                end
                m_tx[i]   = m_active[i] ? m_bits[i][m_pos[i] / CPB] : 1'b1;
                m_busy[i] = m_active[i];
                m_done[i] = m_active[i] && (m_pos[i] == m_len[i] - 1);
`ifdef TX_FIFO_EN
                m_ready[i] = (m_qn[i] < DEPTH);
`else
                m_ready[i] = !m_active[i];
`endif
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("tx%0d", i),    32'(tx[i]),    32'(m_tx[i]));
                    chk($sformatf("busy%0d", i),  32'(busy[i]),  32'(m_busy[i]));
                    chk($sformatf("done%0d", i),  32'(done[i]),  32'(m_done[i]));
                    chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(m_ready[i]));
`ifdef TX_FIFO_EN
                    chk($sformatf("level%0d", i), 32'(lvl[i]),   32'(m_qn[i]));
`endif
                end
            end
        end
    end

    // Sends one word and records the Done cycle and one Tx sample per bit period.
    task automatic run_frame(input int i, input logic [8:0] d, input logic [1:0] m,
                             output int done_cyc, output logic [15:0] pat, output logic rdy_after);
        @(negedge clk);
        send[i] = 1'b1;
        data[i] = d;
        mode[i] = m;
        @(negedge clk);
        send[i]  = 1'b0;
        done_cyc = -1;
        pat      = '0;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            int fc;
            fc = c - (LAT - 1);
            if (fc >= 1 && ((fc - 1) % CPB) == 1 && ((fc - 1) / CPB) < 16) pat[(fc - 1) / CPB] = tx[i];
            if (done[i]) done_cyc = c;
            @(negedge clk);
        end
        rdy_after = ready[i];
    endtask

    initial begin
        int         dc;
        logic [15:0] pat;
        logic       ra;
        int         ndone;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            send[i] = 1'b0;
            data[i] = '0;
            mode[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        check_en = 1'b1;
        chk("reset_ready", 32'(ready[0]), 32'd1);
        chk("reset_tx",    32'(tx[0]),    32'd1);
        chk("reset_busy",  32'(busy[0]),  32'd0);
        chk("reset_done",  32'(done[0]),  32'd0);

        run_frame(0, 9'h0A5, 2'b00, dc, pat, ra);
        chk("a5_done_cycle", 32'(dc), 32'(40 + LAT - 1));
        chk("a5_pattern", 32'(pat[9:0]), 32'b1101001010);
        chk("a5_ready_after", 32'(ra), 32'd1);

        run_frame(0, 9'h007, 2'b01, dc, pat, ra);
        chk("even_done_cycle", 32'(dc), 32'(44 + LAT - 1));
        chk("even_parity_bit", 32'(pat[9]), 32'd1);
        run_frame(0, 9'h007, 2'b10, dc, pat, ra);
        chk("odd_done_cycle", 32'(dc), 32'(44 + LAT - 1));
        chk("odd_parity_bit", 32'(pat[9]), 32'd0);

        run_frame(1, 9'h01F, 2'b10, dc, pat, ra);
        chk("w5_done_cycle", 32'(dc), 32'(36 + LAT - 1));
        chk("w5_pattern", 32'(pat[8:0]), 32'b110111110);

        // Send mid-frame: ignored without a FIFO, queued with one.
        @(negedge clk);
        send[0] = 1'b1;
        data[0] = 9'h03C;
        mode[0] = 2'b00;
        @(negedge clk);
        ndone = 0;
        for (int c = 1; c <= 100; c++) begin
            send[0] = (c == 10);
            data[0] = (c == 10) ? 9'h0FF : 9'h03C;
            if (done[0]) ndone++;
            @(negedge clk);
        end
        send[0] = 1'b0;
`ifdef TX_FIFO_EN
        chk("midframe_done_count", 32'(ndone), 32'd2);
`else
        chk("midframe_done_count", 32'(ndone), 32'd1);
`endif

        // Reset during data bit 3.
        @(negedge clk);
        send[0] = 1'b1;
        data[0] = 9'h0A5;
        @(negedge clk);
        send[0] = 1'b0;
        repeat (17 + LAT - 1) @(negedge clk);
        chk("prereset_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx",    32'(tx[0]),    32'd1);
        chk("abort_busy",  32'(busy[0]),  32'd0);
        chk("abort_ready", 32'(ready[0]), 32'd1);
        @(negedge clk);
        chk("abort_tx_hold", 32'(tx[0]), 32'd1);
        run_frame(0, 9'h0A5, 2'b00, dc, pat, ra);
        chk("clean_done_cycle", 32'(dc), 32'(40 + LAT - 1));
        chk("clean_pattern", 32'(pat[9:0]), 32'b1101001010);

`ifdef TX_FIFO_EN
        begin
            int pushes;
            int nd;
            int dt [5];
            bit saw_full;
            pushes   = 0;
            nd       = 0;
            saw_full = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (done[0] && nd < 5) begin
                    dt[nd] = c;
                    nd++;
                end
                if (!ready[0]) saw_full = 1'b1;
                if (pushes < 5) begin
                    send[0] = 1'b1;
                    data[0] = 9'(8'h30 + pushes);
                    mode[0] = 2'b00;
                    if (ready[0]) pushes++;
                end else begin
                    send[0] = 1'b0;
                end
            end
            send[0] = 1'b0;
            chk("fifo_done_count", 32'(nd), 32'd5);
            for (int k = 1; k < 5; k++) chk($sformatf("fifo_spacing%0d", k), 32'(dt[k] - dt[k-1]), 32'd40);
            chk("fifo_filled", 32'(saw_full), 32'd1);
        end
`endif

        // Randomised traffic on both instances, including Sends while busy and occasional resets.
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                send[i] = ($urandom_range(0, 3) == 0);
                data[i] = 9'($urandom);
                mode[i] = 2'($urandom);
            end
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) send[i] = 1'b0;
        repeat (300) @(negedge clk);
        chk("final_idle_busy0", 32'(busy[0]), 32'd0);
        chk("final_idle_tx1",   32'(tx[1]),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
